// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator: mode encodings, the per-cycle
// action decode, a table of primitive tap masks, and the one-step
// next-state function used by the combinational datapath.
package lfsr_pkg;

    localparam int MAX_WIDTH = 32;

    localparam logic MODE_PRBS = 1'b0;
    localparam logic MODE_MISR = 1'b1;

    // What the register bank does on the coming edge.
    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_STEP,
        ACT_WRAP,
        ACT_RECOVER,
        ACT_MISR
    } action_e;

    // Maximal-length tap masks. Bit i set means stage i is tapped, with the
    // top stage of each width always present.
    function automatic logic [MAX_WIDTH-1:0] primitive_taps(input int width);
        case (width)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return '0;
        endcase
    endfunction

    // Ones in the low `width` bits.
    function automatic logic [MAX_WIDTH-1:0] width_mask(input int width);
        if (width >= MAX_WIDTH) begin
            return '1;
        end
        return (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
    endfunction

    // One PRBS step of a `width`-bit register held in the low bits of `cur`.
    // Fibonacci feeds the parity of the tapped stages into stage 0; Galois
    // folds the mask into the shifted value whenever the top stage is set.
    function automatic logic [MAX_WIDTH-1:0] lfsr_step(
        input logic [MAX_WIDTH-1:0] cur,
        input logic [MAX_WIDTH-1:0] taps,
        input int                   width,
        input logic                 galois
    );
        logic [MAX_WIDTH-1:0] mask;
        logic [MAX_WIDTH-1:0] shifted;
        logic                 msb;
        logic                 fb;
        mask    = width_mask(width);
        shifted = (cur << 1) & mask;
        msb     = |(cur & (mask ^ (mask >> 1)));
        fb      = ^(cur & taps & mask);
        if (galois) begin
            return shifted ^ (msb ? (taps & mask) : '0);
        end
        return shifted | MAX_WIDTH'(fb);
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-state logic: one Fibonacci or Galois step of the
// current state, optionally XORed with the signature input for MISR use.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] TAPS   = WIDTH'(primitive_taps(WIDTH)),
    parameter bit               GALOIS = 1'b0
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             misr_en,
    input  logic [WIDTH-1:0] sig_in,
    output logic [WIDTH-1:0] nxt
);

    // Step the state, then fold in the compression input when in MISR mode.
    always_comb begin
        nxt = WIDTH'(lfsr_step(MAX_WIDTH'(cur), MAX_WIDTH'(TAPS), WIDTH, GALOIS))
              ^ (misr_en ? sig_in : '0);
    end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR / MISR generator. Holds the state, the reference value
// used for period-wrap detection, the step counter and the sticky lock-up
// flag. Priority on every edge is reset, then load, then enable.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] TAPS   = WIDTH'(primitive_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(1),
    parameter bit               GALOIS = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             mode,
    input  logic [WIDTH-1:0] sig_in,
    output logic [WIDTH-1:0] q,
    output logic             bit_out,
    output logic             lockup,
    output logic             wrap,
    output logic [WIDTH-1:0] step_cnt
);

    logic [WIDTH-1:0] ref_val;
    logic             mode_seen;
    logic             mode_changed;
    logic [WIDTH-1:0] nxt;
    action_e          action;

    lfsr_next #(
        .WIDTH  (WIDTH),
        .TAPS   (TAPS),
        .GALOIS (GALOIS)
    ) u_next (
        .cur     (q),
        .misr_en (mode == MODE_MISR),
        .sig_in  (sig_in),
        .nxt     (nxt)
    );

    // Decode what this edge does; wrap is judged against the reference value.
    always_comb begin
        // NOTE: default assigned first so every path drives action and no latch is inferred.
        action = ACT_HOLD;
        if (load) begin
            action = ACT_LOAD;
        end else if (en) begin
            if (mode == MODE_MISR) begin
                action = ACT_MISR;
            end else if (q == '0) begin
                action = ACT_RECOVER;
            end else if (nxt == ref_val) begin
                action = ACT_WRAP;
            end else begin
                action = ACT_STEP;
            end
        end
    end

    assign mode_changed = (mode != mode_seen);
    assign bit_out      = q[WIDTH-1];

    // State register and wrap reference.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            q       <= SEED;
            ref_val <= SEED;
        end else begin
            case (action)
                ACT_LOAD: begin
                    q       <= din;
                    ref_val <= din;
                end
                ACT_RECOVER: begin
                    q       <= SEED;
                    ref_val <= SEED;
                end
                ACT_STEP, ACT_WRAP, ACT_MISR: begin
                    q <= nxt;
                end
                default: begin
                end
            endcase
        end
    end

    // Step counter: restarts on load, recovery, wrap or any mode change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_cnt <= '0;
        end else if (mode_changed) begin
            step_cnt <= '0;
        end else begin
            case (action)
                ACT_LOAD, ACT_RECOVER, ACT_WRAP: step_cnt <= '0;
                ACT_STEP, ACT_MISR:              step_cnt <= step_cnt + WIDTH'(1);
                default: begin
                end
            endcase
        end
    end

    // Status flags: one-cycle wrap pulse, sticky lock-up, registered mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrap      <= 1'b0;
            lockup    <= 1'b0;
            mode_seen <= MODE_PRBS;
        end else begin
            wrap      <= (action == ACT_WRAP);
            mode_seen <= mode;
            if (action == ACT_LOAD) begin
                lockup <= 1'b0;
            end else if (action == ACT_RECOVER) begin
                lockup <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen. Three instances share one set of inputs:
// unit 0 Fibonacci with mask B8, unit 1 Galois with mask B8, unit 2 Galois
// with the primitive mask 1D. Expected values are queued as stimulus is
// driven and compared after the following clock edge.
module tb_lfsr_gen;

    localparam int N = 3;

    typedef enum {F_Q, F_CNT, F_LOCK, F_WRAP, F_BIT} field_e;

    typedef struct {
        string      tag;
        int         unit;
        field_e     fld;
        logic [7:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       load;
    logic       mode;
    logic [7:0] din;
    logic [7:0] sig_in;

    logic [7:0] q_o    [N];
    logic       bit_o  [N];
    logic       lock_o [N];
    logic       wrap_o [N];
    logic [7:0] cnt_o  [N];

    exp_t       sb [$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] fib_first [4] = '{8'h02, 8'h04, 8'h08, 8'h11};

    always #5 clk = ~clk;

    lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .GALOIS(1'b0)) u_fib (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .din(din), .mode(mode),
        .sig_in(sig_in), .q(q_o[0]), .bit_out(bit_o[0]), .lockup(lock_o[0]),
        .wrap(wrap_o[0]), .step_cnt(cnt_o[0])
    );

    lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .GALOIS(1'b1)) u_gal (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .din(din), .mode(mode),
        .sig_in(sig_in), .q(q_o[1]), .bit_out(bit_o[1]), .lockup(lock_o[1]),
        .wrap(wrap_o[1]), .step_cnt(cnt_o[1])
    );

    lfsr_gen #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'h01), .GALOIS(1'b1)) u_galp (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .din(din), .mode(mode),
        .sig_in(sig_in), .q(q_o[2]), .bit_out(bit_o[2]), .lockup(lock_o[2]),
        .wrap(wrap_o[2]), .step_cnt(cnt_o[2])
    );

    // Reference steps, written directly from the polynomials.
    function automatic logic [7:0] fib_b8(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {s[6:0], fb};
    endfunction

    function automatic logic [7:0] gal_1d(input logic [7:0] s);
        return s[7] ? ({s[6:0], 1'b0} ^ 8'h1D) : {s[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] observe(input int unit, input field_e f);
        case (f)
            F_Q:     return q_o[unit];
            F_CNT:   return cnt_o[unit];
            F_LOCK:  return {7'd0, lock_o[unit]};
            F_WRAP:  return {7'd0, wrap_o[unit]};
            default: return {7'd0, bit_o[unit]};
        endcase
    endfunction

    task automatic expect_val(input string tag, input int unit, input field_e f,
                              input logic [7:0] v);
        exp_t e;
        e = '{tag, unit, f, v};
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t       e;
        logic [7:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.unit, e.fld);
            n_tests++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s[u%0d]: observed %h expected %h", e.tag, e.unit, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] m;
        rst_n = 1'b0; en = 1'b0; load = 1'b0; mode = 1'b0;
        din = 8'h00; sig_in = 8'h00;
        tick();
        tick();

        // Reset state of every unit.
        for (int u = 0; u < N; u++) begin
            expect_val("reset_q",    u, F_Q,    8'h01);
            expect_val("reset_bit",  u, F_BIT,  8'h00);
            expect_val("reset_lock", u, F_LOCK, 8'h00);
            expect_val("reset_wrap", u, F_WRAP, 8'h00);
            expect_val("reset_cnt",  u, F_CNT,  8'h00);
        end
        check();

        // Fibonacci full period from the seed.
        rst_n = 1'b1; en = 1'b1; m = 8'h01;
        for (int k = 1; k <= 255; k++) begin
            m = fib_b8(m);
            expect_val("fib_q",    0, F_Q,    m);
            expect_val("fib_bit",  0, F_BIT,  {7'd0, m[7]});
            expect_val("fib_cnt",  0, F_CNT,  (k == 255) ? 8'd0 : 8'(k));
            expect_val("fib_wrap", 0, F_WRAP, (k == 255) ? 8'd1 : 8'd0);
            if (k <= 4) expect_val("fib_first", 0, F_Q, fib_first[k-1]);
            if (k == 255) expect_val("fib_period_q", 0, F_Q, 8'h01);
            tick();
        end
        expect_val("after_wrap_q",    0, F_Q,    8'h02);
        expect_val("after_wrap_wrap", 0, F_WRAP, 8'h00);
        expect_val("after_wrap_cnt",  0, F_CNT,  8'h01);
        tick();

        // Enable low: everything holds.
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            expect_val("hold_q",   0, F_Q,   8'h02);
            expect_val("hold_cnt", 0, F_CNT, 8'h01);
            tick();
        end

        // Mode toggle clears the counter only.
        mode = 1'b1;
        expect_val("mode_q",   0, F_Q,   8'h02);
        expect_val("mode_cnt", 0, F_CNT, 8'h00);
        tick();
        mode = 1'b0; en = 1'b1;
        expect_val("mode_back_q",   0, F_Q,   8'h04);
        expect_val("mode_back_cnt", 0, F_CNT, 8'h00);
        tick();
        expect_val("resume_q",   0, F_Q,   8'h08);
        expect_val("resume_cnt", 0, F_CNT, 8'h01);
        tick();

        // Load beats enable; reset beats load.
        load = 1'b1; din = 8'hC8;
        for (int u = 0; u < N; u++) begin
            expect_val("load_en_q",   u, F_Q,   8'hC8);
            expect_val("load_en_cnt", u, F_CNT, 8'h00);
        end
        tick();
        rst_n = 1'b0;
        for (int u = 0; u < N; u++) begin
            expect_val("rst_load_q",   u, F_Q,   8'h01);
            expect_val("rst_load_cnt", u, F_CNT, 8'h00);
        end
        tick();
        rst_n = 1'b1;

        // Galois: first step from 80, then a full period on the primitive mask.
        load = 1'b1; en = 1'b0; din = 8'h80;
        expect_val("gal_load_q", 1, F_Q, 8'h80);
        expect_val("gal_load_q", 2, F_Q, 8'h80);
        tick();
        load = 1'b0; en = 1'b1; m = 8'h80;
        for (int k = 1; k <= 255; k++) begin
            m = gal_1d(m);
            expect_val("galp_q",    2, F_Q,    m);
            expect_val("galp_wrap", 2, F_WRAP, (k == 255) ? 8'd1 : 8'd0);
            expect_val("galp_cnt",  2, F_CNT,  (k == 255) ? 8'd0 : 8'(k));
            if (k == 1) begin
                expect_val("gal_b8_first", 1, F_Q, 8'hB8);
                expect_val("galp_first",   2, F_Q, 8'h1D);
            end
            if (k == 255) expect_val("galp_period_q", 2, F_Q, 8'h80);
            tick();
        end

        // Zero load then PRBS step: recovery to the seed, sticky lock-up.
        en = 1'b0; load = 1'b1; din = 8'h00;
        expect_val("zero_load_q",    0, F_Q,    8'h00);
        expect_val("zero_load_lock", 0, F_LOCK, 8'h00);
        tick();
        load = 1'b0; en = 1'b1;
        expect_val("recover_q",    0, F_Q,    8'h01);
        expect_val("recover_lock", 0, F_LOCK, 8'h01);
        expect_val("recover_wrap", 0, F_WRAP, 8'h00);
        expect_val("recover_cnt",  0, F_CNT,  8'h00);
        tick();
        m = 8'h01;
        for (int k = 0; k < 3; k++) begin
            m = fib_b8(m);
            expect_val("sticky_q",    0, F_Q,    m);
            expect_val("sticky_lock", 0, F_LOCK, 8'h01);
            expect_val("sticky_wrap", 0, F_WRAP, 8'h00);
            tick();
        end
        en = 1'b0; load = 1'b1; din = 8'h33;
        expect_val("unlock_q",    0, F_Q,    8'h33);
        expect_val("unlock_lock", 0, F_LOCK, 8'h00);
        tick();

        // MISR: compression, zero state legal, no lock-up or wrap.
        din = 8'h00;
        expect_val("misr_load_q", 0, F_Q, 8'h00);
        tick();
        load = 1'b0; mode = 1'b1; en = 1'b1; sig_in = 8'h5A;
        expect_val("misr1_q",    0, F_Q,    8'h5A);
        expect_val("misr1_cnt",  0, F_CNT,  8'h00);
        expect_val("misr1_lock", 0, F_LOCK, 8'h00);
        expect_val("misr1_wrap", 0, F_WRAP, 8'h00);
        tick();
        sig_in = 8'h00;
        expect_val("misr2_q",    0, F_Q,    8'hB4);
        expect_val("misr2_lock", 0, F_LOCK, 8'h00);
        expect_val("misr2_wrap", 0, F_WRAP, 8'h00);
        tick();
        sig_in = 8'h69;
        expect_val("misr_zero_q",    0, F_Q,    8'h00);
        expect_val("misr_zero_lock", 0, F_LOCK, 8'h00);
        tick();
        sig_in = 8'h00;
        expect_val("misr_from_zero_q",    0, F_Q,    8'h00);
        expect_val("misr_from_zero_lock", 0, F_LOCK, 8'h00);
        expect_val("misr_from_zero_wrap", 0, F_WRAP, 8'h00);
        tick();
        en = 1'b0; mode = 1'b0;
        expect_val("misr_exit_cnt", 0, F_CNT, 8'h00);
        expect_val("misr_exit_q",   0, F_Q,   8'h00);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
